// File: rtl/syn_gpu_pkg.sv
// Shared GPU pipeline types: pixel colour, coordinate widths and rectangle-fill job/FSM types.
package syn_gpu_pkg;

    localparam int unsigned P_X_W    = 10;
    localparam int unsigned P_Y_W    = 10;
    localparam int unsigned P_C_W    = 8;
    localparam int unsigned P_DIST_W = 8;
    localparam int unsigned P_NORM_W = 8;

    typedef struct packed {
        logic [P_C_W-1:0] y;
        logic [P_C_W-1:0] cb;
        logic [P_C_W-1:0] cr;
    } pxl_ycbcr_t;

    typedef enum logic [1:0] {
        FSM_IDLE = 2'd0,
        FSM_LOAD = 2'd1,
        FSM_FILL = 2'd2,
        FSM_DONE = 2'd3
    } syn_rect_fill_fsm_t;

    typedef struct packed {
        logic [P_X_W-1:0] x0;
        logic [P_X_W-1:0] x1;
        logic [P_Y_W-1:0] y0;
        logic [P_Y_W-1:0] y1;
        pxl_ycbcr_t       pxl;
    } syn_rect_job_t;

endpackage

// File: rtl/syn_rect_fill_if.sv
// Pixel transfer port between GPU pipeline stages; master drives beats, slave returns ready.
interface syn_pxl_xfr_intf
    import syn_gpu_pkg::*;
#(
    parameter int unsigned WIDTHX = P_X_W,
    parameter int unsigned WIDTHY = P_Y_W
);
    logic                pxl_wr_valid;
    logic                pxl_rd_valid;
    logic                ready;
    logic [WIDTHX-1:0]   posx;
    logic [WIDTHY-1:0]   posy;
    pxl_ycbcr_t          pxl;
    logic [P_DIST_W-1:0] misc_info_dist;
    logic [P_NORM_W-1:0] misc_info_norm;

    modport master (
        output pxl_wr_valid, pxl_rd_valid, posx, posy, pxl, misc_info_dist, misc_info_norm,
        input  ready
    );

    modport slave (
        input  pxl_wr_valid, pxl_rd_valid, posx, posy, pxl, misc_info_dist, misc_info_norm,
        output ready
    );
endinterface

// File: rtl/syn_rect_fill_raster_cntr.sv
// Raster-order coordinate walker over [xs..xe]x[ys..ye]; flags the final coordinate.
module syn_raster_cntr
    import syn_gpu_pkg::*;
#(
    parameter int unsigned WIDTHX = P_X_W,
    parameter int unsigned WIDTHY = P_Y_W
) (
    input  logic              clk_ir,
    input  logic              rst_ih,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [WIDTHX-1:0] xs_i,
    input  logic [WIDTHX-1:0] xe_i,
    input  logic [WIDTHY-1:0] ys_i,
    input  logic [WIDTHY-1:0] ye_i,
    output logic [WIDTHX-1:0] cur_x_o,
    output logic [WIDTHY-1:0] cur_y_o,
    output logic              last_o
);
    logic [WIDTHX-1:0] xs_q, xs_d, xe_q, xe_d, cur_x_q, cur_x_d;
    logic [WIDTHY-1:0] ye_q, ye_d, cur_y_q, cur_y_d;
    logic              last_q, last_d;

    // Wrap to xs is checked before incrementing, so x never exceeds xe.
    always_comb begin
        xs_d    = xs_q;
        xe_d    = xe_q;
        ye_d    = ye_q;
        cur_x_d = cur_x_q;
        cur_y_d = cur_y_q;
        last_d  = last_q;
        if (load_i) begin
            xs_d    = xs_i;
            xe_d    = xe_i;
            ye_d    = ye_i;
            cur_x_d = xs_i;
            cur_y_d = ys_i;
            last_d  = (xs_i == xe_i) && (ys_i == ye_i);
        end else if (step_i && !last_q) begin
            if (cur_x_q == xe_q) begin
                cur_x_d = xs_q;
                cur_y_d = cur_y_q + WIDTHY'(1);
            end else begin
                cur_x_d = cur_x_q + WIDTHX'(1);
            end
            last_d = (cur_x_d == xe_q) && (cur_y_d == ye_q);
        end
    end

    always_ff @(posedge clk_ir or posedge rst_ih) begin
        if (rst_ih) begin
            xs_q    <= '0;
            xe_q    <= '0;
            ye_q    <= '0;
            cur_x_q <= '0;
            cur_y_q <= '0;
            last_q  <= 1'b0;
        end else begin
            xs_q    <= xs_d;
            xe_q    <= xe_d;
            ye_q    <= ye_d;
            cur_x_q <= cur_x_d;
            cur_y_q <= cur_y_d;
            last_q  <= last_d;
        end
    end

    assign cur_x_o = cur_x_q;
    assign cur_y_o = cur_y_q;
    assign last_o  = last_q;
endmodule

// File: rtl/syn_rect_fill.sv
// Rectangle fill engine: takes one corner-pair job and streams every covered pixel in raster order.
module syn_rect_fill
    import syn_gpu_pkg::*;
#(
    parameter int unsigned WIDTHX = P_X_W,
    parameter int unsigned WIDTHY = P_Y_W
) (
    input  logic              clk_ir,
    input  logic              rst_ih,
    input  logic              job_valid_i,
    output logic              job_ready_o,
    input  logic [WIDTHX-1:0] job_x0_i,
    input  logic [WIDTHX-1:0] job_x1_i,
    input  logic [WIDTHY-1:0] job_y0_i,
    input  logic [WIDTHY-1:0] job_y1_i,
    input  pxl_ycbcr_t        job_pxl_i,
    output logic              busy_o,
    output logic              done_o,
    syn_pxl_xfr_intf.master   pxl_xfr
);
    syn_rect_fill_fsm_t state_q, state_d;
    syn_rect_job_t      job_q, job_d;
    logic               job_ready_q, busy_q, done_q, valid_q;
    logic               load_c, step_c, last_c;
    logic [WIDTHX-1:0]  x0_c, x1_c, xs_c, xe_c, cur_x_c;
    logic [WIDTHY-1:0]  y0_c, y1_c, ys_c, ye_c, cur_y_c;

    // Corner normalisation, consumed by the walker during LOAD.
    always_comb begin
        x0_c = WIDTHX'(job_q.x0);
        x1_c = WIDTHX'(job_q.x1);
        y0_c = WIDTHY'(job_q.y0);
        y1_c = WIDTHY'(job_q.y1);
        xs_c = (x0_c < x1_c) ? x0_c : x1_c;
        xe_c = (x0_c < x1_c) ? x1_c : x0_c;
        ys_c = (y0_c < y1_c) ? y0_c : y1_c;
        ye_c = (y0_c < y1_c) ? y1_c : y0_c;
    end

    always_comb begin
        state_d = state_q;
        job_d   = job_q;
        load_c  = 1'b0;
        step_c  = 1'b0;
        case (state_q)
            FSM_IDLE: begin
                if (job_valid_i) begin
                    job_d.x0  = P_X_W'(job_x0_i);
                    job_d.x1  = P_X_W'(job_x1_i);
                    job_d.y0  = P_Y_W'(job_y0_i);
                    job_d.y1  = P_Y_W'(job_y1_i);
                    job_d.pxl = job_pxl_i;
                    state_d   = FSM_LOAD;
                end
            end
            FSM_LOAD: begin
                load_c  = 1'b1;
                state_d = FSM_FILL;
            end
            FSM_FILL: begin
                if (pxl_xfr.ready) begin
                    step_c = 1'b1;
                    if (last_c) state_d = FSM_DONE;
                end
            end
            FSM_DONE: state_d = FSM_IDLE;
            default:  state_d = FSM_IDLE;
        endcase
    end

    // Status and valid are registered from the next state so they align with it.
    always_ff @(posedge clk_ir or posedge rst_ih) begin
        if (rst_ih) begin
            state_q     <= FSM_IDLE;
            job_q       <= '0;
            job_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            job_q       <= job_d;
            job_ready_q <= (state_d == FSM_IDLE);
            busy_q      <= (state_d != FSM_IDLE);
            done_q      <= (state_d == FSM_DONE);
            valid_q     <= (state_d == FSM_FILL);
        end
    end

    syn_raster_cntr #(
        .WIDTHX (WIDTHX),
        .WIDTHY (WIDTHY)
    ) u_raster_cntr (
        .clk_ir  (clk_ir),
        .rst_ih  (rst_ih),
        .load_i  (load_c),
        .step_i  (step_c),
        .xs_i    (xs_c),
        .xe_i    (xe_c),
        .ys_i    (ys_c),
        .ye_i    (ye_c),
        .cur_x_o (cur_x_c),
        .cur_y_o (cur_y_c),
        .last_o  (last_c)
    );

    assign job_ready_o            = job_ready_q;
    assign busy_o                 = busy_q;
    assign done_o                 = done_q;
    assign pxl_xfr.pxl_wr_valid   = valid_q;
    assign pxl_xfr.pxl_rd_valid   = 1'b0;
    assign pxl_xfr.posx           = cur_x_c;
    assign pxl_xfr.posy           = cur_y_c;
    assign pxl_xfr.pxl            = job_q.pxl;
    assign pxl_xfr.misc_info_dist = '0;
    assign pxl_xfr.misc_info_norm = '0;
endmodule

// File: tb/tb_syn_rect_fill.sv
// Bench for syn_rect_fill: raster-order beat model with per-cycle checking plus directed jobs.
module tb_syn_rect_fill;
    import syn_gpu_pkg::*;

    localparam int unsigned PX   = P_X_W;
    localparam int unsigned PY   = P_Y_W;
    localparam int          XMAX = (1 << PX) - 1;

    typedef struct {
        int x;
        int y;
    } beat_t;

    logic            clk_ir = 1'b0;
    logic            rst_ih = 1'b1;
    logic            job_valid;
    logic            job_ready;
    logic [PX-1:0]   job_x0, job_x1;
    logic [PY-1:0]   job_y0, job_y1;
    pxl_ycbcr_t      job_pxl;
    logic            busy, done;

    int              n_checks = 0;
    int              n_err    = 0;
    int              n_xfer   = 0;
    int              done_seen = 0;
    bit              ready_mode = 1'b0;
    logic [31:0]     rdy_pat = 32'b0110_1011_0010_1110_1001_0011_0101_1101;
    int              rdy_idx = 0;

    beat_t           model_q[$];
    beat_t           exp_q[$];
    pxl_ycbcr_t      exp_pxl;
    bit              exp_done_next = 1'b0;
    bit              prev_stall    = 1'b0;
    logic [PX-1:0]   prev_x;
    logic [PY-1:0]   prev_y;
    pxl_ycbcr_t      prev_p;
    beat_t           b;

    always #5 clk_ir = ~clk_ir;

    syn_pxl_xfr_intf #(.WIDTHX(PX), .WIDTHY(PY)) bus ();

    syn_rect_fill #(.WIDTHX(PX), .WIDTHY(PY)) dut (
        .clk_ir      (clk_ir),
        .rst_ih      (rst_ih),
        .job_valid_i (job_valid),
        .job_ready_o (job_ready),
        .job_x0_i    (job_x0),
        .job_x1_i    (job_x1),
        .job_y0_i    (job_y0),
        .job_y1_i    (job_y1),
        .job_pxl_i   (job_pxl),
        .busy_o      (busy),
        .done_o      (done),
        .pxl_xfr     (bus.master)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Every covered pixel, rows top to bottom, columns left to right.
    task automatic build_model(input int x0, input int x1, input int y0, input int y1);
        int xs, xe, ys, ye;
        xs = (x0 < x1) ? x0 : x1;
        xe = (x0 < x1) ? x1 : x0;
        ys = (y0 < y1) ? y0 : y1;
        ye = (y0 < y1) ? y1 : y0;
        model_q.delete();
        for (int y = ys; y <= ye; y++)
            for (int x = xs; x <= xe; x++)
                model_q.push_back('{x: x, y: y});
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_job_ready"}, 64'(job_ready), 64'd1);
        chk({tag, "_busy"},      64'(busy), 64'd0);
        chk({tag, "_done"},      64'(done), 64'd0);
        chk({tag, "_wr_valid"},  64'(bus.pxl_wr_valid), 64'd0);
        chk({tag, "_rd_valid"},  64'(bus.pxl_rd_valid), 64'd0);
        chk({tag, "_posx"},      64'(bus.posx), 64'd0);
        chk({tag, "_posy"},      64'(bus.posy), 64'd0);
        chk({tag, "_pxl"},       64'(bus.pxl), 64'd0);
        chk({tag, "_dist"},      64'(bus.misc_info_dist), 64'd0);
        chk({tag, "_norm"},      64'(bus.misc_info_norm), 64'd0);
    endtask

    task automatic wait_job_ready();
        for (int i = 0; i < 100 && job_ready !== 1'b1; i++) begin
            @(posedge clk_ir); #1;
        end
        chk("job_ready_wait", 64'(job_ready), 64'd1);
    endtask

    task automatic present_job(input int x0, input int x1, input int y0, input int y1,
                               input pxl_ycbcr_t p);
        job_x0    = PX'(x0);
        job_x1    = PX'(x1);
        job_y0    = PY'(y0);
        job_y1    = PY'(y1);
        job_pxl   = p;
        job_valid = 1'b1;
        @(posedge clk_ir); #1;
        job_valid = 1'b0;
    endtask

    task automatic run_job(input int x0, input int x1, input int y0, input int y1,
                           input pxl_ycbcr_t p, input bit intrude, input bit pat_on);
        int w, h, busy_cnt, guard;
        w = ((x0 < x1) ? x1 - x0 : x0 - x1) + 1;
        h = ((y0 < y1) ? y1 - y0 : y0 - y1) + 1;
        ready_mode = 1'b0;
        wait_job_ready();
        build_model(x0, x1, y0, y1);
        exp_q     = model_q;
        exp_pxl   = p;
        n_xfer    = 0;
        done_seen = 0;
        ready_mode = pat_on;
        present_job(x0, x1, y0, y1, p);
        chk("load_busy",      64'(busy), 64'd1);
        chk("load_job_ready", 64'(job_ready), 64'd0);
        chk("load_no_valid",  64'(bus.pxl_wr_valid), 64'd0);
        busy_cnt = 1;
        @(posedge clk_ir); #1;
        chk("first_valid_latency", 64'(bus.pxl_wr_valid), 64'd1);
        guard = 0;
        while (busy === 1'b1 && guard < 2000) begin
            busy_cnt++;
            if (intrude && guard < 3) begin
                job_x0 = PX'(40); job_x1 = PX'(41);
                job_y0 = PY'(40); job_y1 = PY'(41);
                job_valid = 1'b1;
            end else begin
                job_valid = 1'b0;
            end
            guard++;
            @(posedge clk_ir); #1;
        end
        job_valid  = 1'b0;
        ready_mode = 1'b0;
        chk("job_timeout", 64'(guard < 2000), 64'd1);
        repeat (3) begin @(posedge clk_ir); #1; end
        chk("beats_left",  64'(exp_q.size()), 64'd0);
        chk("xfer_count",  64'(n_xfer), 64'(w * h));
        chk("done_pulses", 64'(done_seen), 64'd1);
        if (!pat_on) chk("busy_cycles", 64'(busy_cnt), 64'(w * h + 2));
        chk("idle_job_ready", 64'(job_ready), 64'd1);
        chk("idle_no_valid",  64'(bus.pxl_wr_valid), 64'd0);
    endtask

    // Backpressure driver: always ready, or a fixed irregular pattern.
    initial begin
        bus.ready = 1'b1;
        forever begin
            @(posedge clk_ir); #1;
            if (ready_mode) begin
                bus.ready = rdy_pat[rdy_idx];
                rdy_idx   = (rdy_idx + 1) % 32;
            end else begin
                bus.ready = 1'b1;
            end
        end
    end

    // Per-cycle compare against the expected beat queue.
    always @(negedge clk_ir) begin
        if (rst_ih) begin
            exp_q.delete();
            exp_done_next = 1'b0;
            prev_stall    = 1'b0;
        end else begin
            chk("done_timing", 64'(done), 64'(exp_done_next));
            if (done === 1'b1) done_seen++;
            chk("rd_valid_zero", 64'(bus.pxl_rd_valid), 64'd0);
            chk("dist_zero", 64'(bus.misc_info_dist), 64'd0);
            chk("norm_zero", 64'(bus.misc_info_norm), 64'd0);
            if (prev_stall) begin
                chk("stall_valid", 64'(bus.pxl_wr_valid), 64'd1);
                chk("stall_posx",  64'(bus.posx), 64'(prev_x));
                chk("stall_posy",  64'(bus.posy), 64'(prev_y));
                chk("stall_pxl",   64'(bus.pxl), 64'(prev_p));
            end
            exp_done_next = 1'b0;
            if (bus.pxl_wr_valid === 1'b1 && bus.ready === 1'b1) begin
                n_xfer++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 64'(bus.posx), 64'hFFFF);
                end else begin
                    b = exp_q.pop_front();
                    chk("beat_posx", 64'(bus.posx), 64'(b.x));
                    chk("beat_posy", 64'(bus.posy), 64'(b.y));
                    chk("beat_pxl",  64'(bus.pxl), 64'(exp_pxl));
                    if (exp_q.size() == 0) exp_done_next = 1'b1;
                end
            end
            prev_stall = (bus.pxl_wr_valid === 1'b1) && (bus.ready !== 1'b1);
            prev_x = bus.posx;
            prev_y = bus.posy;
            prev_p = bus.pxl;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        job_valid = 1'b0;
        job_x0 = '0; job_x1 = '0; job_y0 = '0; job_y1 = '0;
        job_pxl = '0;
        rst_ih = 1'b1;
        repeat (3) begin @(posedge clk_ir); #1; end
        chk_reset_outputs("por");
        rst_ih = 1'b0;
        @(posedge clk_ir); #1;

        // Basic 3x2 job; pin the model with hand values.
        build_model(2, 4, 3, 4);
        chk("model1_size", 64'(model_q.size()), 64'd6);
        chk("model1_b0x", 64'(model_q[0].x), 64'd2);
        chk("model1_b0y", 64'(model_q[0].y), 64'd3);
        chk("model1_b3x", 64'(model_q[3].x), 64'd2);
        chk("model1_b3y", 64'(model_q[3].y), 64'd4);
        chk("model1_b5x", 64'(model_q[5].x), 64'd4);
        run_job(2, 4, 3, 4, '{y: 8'h51, cb: 8'h5a, cr: 8'hf0}, 1'b0, 1'b0);

        // 1x1 job.
        build_model(5, 5, 5, 5);
        chk("model2_size", 64'(model_q.size()), 64'd1);
        run_job(5, 5, 5, 5, '{y: 8'h10, cb: 8'h80, cr: 8'h80}, 1'b0, 1'b0);

        // Swapped corners.
        build_model(4, 2, 4, 3);
        chk("model3_b0x", 64'(model_q[0].x), 64'd2);
        chk("model3_b0y", 64'(model_q[0].y), 64'd3);
        chk("model3_b1x", 64'(model_q[1].x), 64'd3);
        run_job(4, 2, 4, 3, '{y: 8'hab, cb: 8'hcd, cr: 8'hef}, 1'b0, 1'b0);

        // 3x3 under irregular backpressure.
        run_job(7, 9, 1, 3, '{y: 8'h22, cb: 8'h33, cr: 8'h44}, 1'b0, 1'b1);

        // Right edge of the X range.
        build_model(XMAX - 1, XMAX, 0, 1);
        chk("model5_b1x", 64'(model_q[1].x), 64'(XMAX));
        chk("model5_b2x", 64'(model_q[2].x), 64'(XMAX - 1));
        run_job(XMAX, XMAX - 1, 1, 0, '{y: 8'h01, cb: 8'h02, cr: 8'h03}, 1'b0, 1'b0);

        // Single column and a job offered while busy.
        run_job(6, 6, 2, 0, '{y: 8'h77, cb: 8'h66, cr: 8'h55}, 1'b0, 1'b0);
        run_job(0, 2, 0, 2, '{y: 8'h99, cb: 8'h88, cr: 8'h77}, 1'b1, 1'b0);

        // Reset after 4 of 9 beats.
        wait_job_ready();
        build_model(10, 12, 20, 22);
        exp_q     = model_q;
        exp_pxl   = '{y: 8'h5e, cb: 8'h6f, cr: 8'h70};
        n_xfer    = 0;
        done_seen = 0;
        present_job(10, 12, 20, 22, exp_pxl);
        for (int i = 0; i < 50 && n_xfer < 4; i++) begin
            @(posedge clk_ir); #1;
        end
        chk("pre_reset_xfers", 64'(n_xfer), 64'd4);
        rst_ih = 1'b1;
        #1;
        chk_reset_outputs("mid");
        @(posedge clk_ir); #1;
        rst_ih = 1'b0;
        repeat (4) begin @(posedge clk_ir); #1; end
        chk("reset_no_done", 64'(done_seen), 64'd0);
        chk("reset_idle_valid", 64'(bus.pxl_wr_valid), 64'd0);

        // Normal job after reset.
        run_job(3, 1, 6, 8, '{y: 8'h42, cb: 8'h24, cr: 8'h18}, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
